// File: rtl/timer_cfg_sequencer.sv
// Timer configuration sequencer: applies software enable/prescaler writes to the counter control
// at safe prescaler boundaries and parks updates while debug halt is active. Optional
// pending-update timeout is enabled by defining TIMER_CFG_TIMEOUT_EN.
module timer_cfg_sequencer (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       cfg_wr,
    input  logic       cfg_timer_en,
    input  logic       cfg_div_en,
    input  logic [3:0] cfg_div_val,
    input  logic       dbg_mode,
    input  logic       dbg_halt_req,
    input  logic       cnt_en,
    output logic       timer_en,
    output logic       div_en,
    output logic [3:0] div_val,
    output logic       halt_req,
    output logic       halt_ack,
    output logic       cfg_busy,
    output logic       div_restart
);

    typedef enum logic [1:0] {StDis, StRun, StPend, StHalt} state_e;

    state_e     state_q;
    logic       shd_timer_en_q;
    logic       shd_div_en_q;
    logic [3:0] shd_div_val_q;

    logic       halt_in;
    logic       wr_off;
    logic       wr_on;
    logic       wr_same;
    logic       pend_apply;
    logic       eff_timer_en;
    logic       eff_div_en;
    logic [3:0] eff_div_val;
    logic       tmo_hit;

    assign halt_in = dbg_mode & dbg_halt_req;
    assign wr_off  = cfg_wr & ~cfg_timer_en;
    assign wr_on   = cfg_wr & cfg_timer_en;
    assign wr_same = (cfg_div_en == div_en) && (cfg_div_val == div_val);

    // A write in the same cycle as an apply takes effect directly, bypassing the shadow.
    assign eff_timer_en = cfg_wr ? cfg_timer_en : shd_timer_en_q;
    assign eff_div_en   = cfg_wr ? cfg_div_en   : shd_div_en_q;
    assign eff_div_val  = cfg_wr ? cfg_div_val  : shd_div_val_q;

`ifdef TIMER_CFG_TIMEOUT_EN
    logic [7:0] tmo_q;

    assign tmo_hit = (tmo_q == 8'hFF);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_q <= 8'h00;
        end else if (state_q == StRun) begin
            tmo_q <= 8'h00;
        end else if (state_q == StPend) begin
            tmo_q <= cfg_wr ? 8'h00 : tmo_q + 8'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign pend_apply = cnt_en | (tmo_hit & ~cfg_wr);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= StDis;
            timer_en       <= 1'b0;
            div_en         <= 1'b0;
            div_val        <= 4'h0;
            halt_req       <= 1'b0;
            halt_ack       <= 1'b0;
            cfg_busy       <= 1'b0;
            div_restart    <= 1'b0;
            shd_timer_en_q <= 1'b0;
            shd_div_en_q   <= 1'b0;
            shd_div_val_q  <= 4'h0;
        end else begin
            div_restart <= 1'b0;
            unique case (state_q)
                StDis: begin
                    if (cfg_wr) begin
                        div_en  <= cfg_div_en;
                        div_val <= cfg_div_val;
                        if (cfg_timer_en) begin
                            timer_en <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                end
                StRun, StPend: begin
                    if (wr_off) begin
                        timer_en <= 1'b0;
                        div_en   <= cfg_div_en;
                        div_val  <= cfg_div_val;
                        cfg_busy <= 1'b0;
                        state_q  <= StDis;
                    end else if (halt_in) begin
                        if (wr_on) begin
                            shd_timer_en_q <= 1'b1;
                            shd_div_en_q   <= cfg_div_en;
                            shd_div_val_q  <= cfg_div_val;
                            cfg_busy       <= 1'b1;
                        end
                        halt_req <= 1'b1;
                        state_q  <= StHalt;
                    end else if (state_q == StRun) begin
                        if (wr_on && !wr_same) begin
                            shd_timer_en_q <= 1'b1;
                            shd_div_en_q   <= cfg_div_en;
                            shd_div_val_q  <= cfg_div_val;
                            cfg_busy       <= 1'b1;
                            state_q        <= StPend;
                        end
                    end else if (pend_apply) begin
                        div_en      <= eff_div_en;
                        div_val     <= eff_div_val;
                        div_restart <= 1'b1;
                        cfg_busy    <= 1'b0;
                        state_q     <= StRun;
                    end else if (wr_on) begin
                        shd_div_en_q  <= cfg_div_en;
                        shd_div_val_q <= cfg_div_val;
                    end
                end
                StHalt: begin
                    if (halt_in) begin
                        halt_ack <= 1'b1;
                        if (cfg_wr) begin
                            shd_timer_en_q <= cfg_timer_en;
                            shd_div_en_q   <= cfg_div_en;
                            shd_div_val_q  <= cfg_div_val;
                            cfg_busy       <= 1'b1;
                        end
                    end else begin
                        halt_req <= 1'b0;
                        halt_ack <= 1'b0;
                        cfg_busy <= 1'b0;
                        state_q  <= StRun;
                        if (cfg_wr || cfg_busy) begin
                            div_en  <= eff_div_en;
                            div_val <= eff_div_val;
                            if (eff_timer_en) begin
                                div_restart <= 1'b1;
                            end else begin
                                timer_en <= 1'b0;
                                state_q  <= StDis;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Self-checking bench for timer_cfg_sequencer: directed scenarios followed by random traffic,
// every output compared each cycle against a behavioural model of the configuration rules.
module tb_timer_cfg_sequencer;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       cfg_wr;
    logic       cfg_timer_en;
    logic       cfg_div_en;
    logic [3:0] cfg_div_val;
    logic       dbg_mode;
    logic       dbg_halt_req;
    logic       cnt_en;
    logic       timer_en;
    logic       div_en;
    logic [3:0] div_val;
    logic       halt_req;
    logic       halt_ack;
    logic       cfg_busy;
    logic       div_restart;

    int n_cmp = 0;
    int n_bad = 0;

    timer_cfg_sequencer dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cfg_wr      (cfg_wr),
        .cfg_timer_en(cfg_timer_en),
        .cfg_div_en  (cfg_div_en),
        .cfg_div_val (cfg_div_val),
        .dbg_mode    (dbg_mode),
        .dbg_halt_req(dbg_halt_req),
        .cnt_en      (cnt_en),
        .timer_en    (timer_en),
        .div_en      (div_en),
        .div_val     (div_val),
        .halt_req    (halt_req),
        .halt_ack    (halt_ack),
        .cfg_busy    (cfg_busy),
        .div_restart (div_restart)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Behavioural model: mode is implied by (m_on, m_halted, m_pend) rather than a state code.
    logic       m_on, m_den, m_req, m_ack, m_pend, m_rst, m_halted, s_on, s_den;
    logic [3:0] m_val, s_val;
    int         m_wait;

    function automatic logic [9:0] outs();
        return {timer_en, div_en, div_val, halt_req, halt_ack, cfg_busy, div_restart};
    endfunction

    function automatic logic [9:0] model_outs();
        return {m_on, m_den, m_val, m_req, m_ack, m_pend, m_rst};
    endfunction

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        {m_on, m_den, m_req, m_ack, m_pend, m_rst, m_halted, s_on, s_den} = '0;
        m_val  = 4'h0;
        s_val  = 4'h0;
        m_wait = 0;
    endtask

    task automatic take_shadow();
        s_on   = cfg_timer_en;
        s_den  = cfg_div_en;
        s_val  = cfg_div_val;
        m_pend = 1'b1;
    endtask

    task automatic model_step();
        logic hin;
        logic apply;
        hin   = dbg_mode & dbg_halt_req;
        m_rst = 1'b0;
        if (!m_on) begin
            if (cfg_wr) begin
                m_den = cfg_div_en;
                m_val = cfg_div_val;
                m_on  = cfg_timer_en;
            end
        end else if (m_halted) begin
            if (hin) begin
                m_ack = 1'b1;
                if (cfg_wr) take_shadow();
            end else begin
                m_halted = 1'b0;
                m_req    = 1'b0;
                m_ack    = 1'b0;
                if (cfg_wr) take_shadow();
                if (m_pend) begin
                    m_den  = s_den;
                    m_val  = s_val;
                    m_pend = 1'b0;
                    if (s_on) m_rst = 1'b1;
                    else m_on = 1'b0;
                end
            end
        end else if (cfg_wr && !cfg_timer_en) begin
            m_on   = 1'b0;
            m_den  = cfg_div_en;
            m_val  = cfg_div_val;
            m_pend = 1'b0;
        end else if (hin) begin
            if (cfg_wr) take_shadow();
            m_halted = 1'b1;
            m_req    = 1'b1;
            m_ack    = 1'b0;
        end else if (!m_pend) begin
            if (cfg_wr && (cfg_div_en != m_den || cfg_div_val != m_val)) begin
                take_shadow();
                m_wait = 0;
            end
        end else begin
`ifdef TIMER_CFG_TIMEOUT_EN
            apply = cnt_en || (m_wait >= 255 && !cfg_wr);
`else
            apply = cnt_en;
`endif
            if (cfg_wr) begin
                take_shadow();
                m_wait = 0;
            end else begin
                m_wait++;
            end
            if (apply) begin
                m_den  = s_den;
                m_val  = s_val;
                m_rst  = 1'b1;
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge sys_clk);
        model_step();
        #1;
        chk(tag, outs(), model_outs());
    endtask

    task automatic drive_wr(input logic ton, input logic den, input logic [3:0] val);
        cfg_wr       = 1'b1;
        cfg_timer_en = ton;
        cfg_div_en   = den;
        cfg_div_val  = val;
    endtask

    task automatic idle();
        cfg_wr = 1'b0;
        cnt_en = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        chk(tag, outs(), 10'h000);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        logic hold_halt;
        sys_rst_n    = 1'b0;
        cfg_wr       = 1'b0;
        cfg_timer_en = 1'b0;
        cfg_div_en   = 1'b0;
        cfg_div_val  = 4'h0;
        dbg_mode     = 1'b0;
        dbg_halt_req = 1'b0;
        cnt_en       = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        chk("reset_outs", outs(), 10'h000);
        sys_rst_n = 1'b1;

        // Enable from DIS
        drive_wr(1'b1, 1'b1, 4'd3);
        step("en_model");
        chk("en_timer_en", 10'(timer_en), 10'd1);
        chk("en_div_val", 10'(div_val), 10'd3);
        chk("en_restart", 10'(div_restart), 10'd0);
        idle();
        step("run_idle");

        // Running prescaler change waits for cnt_en
        drive_wr(1'b1, 1'b1, 4'd5);
        step("pend_model");
        chk("pend_busy", 10'(cfg_busy), 10'd1);
        idle();
        for (int i = 0; i < 3; i++) begin
            step("pend_wait_model");
            chk("pend_wait_busy", {cfg_busy, div_val}, {1'b1, 4'd3});
        end
        cnt_en = 1'b1;
        step("apply_model");
        chk("apply_val_rst", {div_val, div_restart, cfg_busy}, {4'd5, 1'b1, 1'b0});
        cnt_en = 1'b0;
        step("apply_after_model");
        chk("restart_one_cycle", 10'(div_restart), 10'd0);

        // Halt with pending update, write during halt, release applies it
        drive_wr(1'b1, 1'b1, 4'd7);
        step("pend2_model");
        idle();
        dbg_mode     = 1'b1;
        dbg_halt_req = 1'b1;
        step("halt_entry_model");
        chk("halt_req_ack0", {halt_req, halt_ack}, 10'b10);
        step("halt_ack_model");
        chk("halt_ack1", {halt_req, halt_ack}, 10'b11);
        drive_wr(1'b1, 1'b1, 4'd2);
        step("halt_wr_model");
        chk("halt_wr_frozen", {div_val, cfg_busy}, {4'd5, 1'b1});
        idle();
        dbg_halt_req = 1'b0;
        step("halt_rel_model");
        chk("halt_rel", {halt_req, div_val, div_restart}, {1'b0, 4'd2, 1'b1});

        // Disable write in PEND with cnt_en: disable wins
        step("idle2_model");
        drive_wr(1'b1, 1'b1, 4'd9);
        step("pend3_model");
        drive_wr(1'b0, 1'b0, 4'd4);
        cnt_en = 1'b1;
        step("pend_dis_model");
        chk("pend_dis", {timer_en, cfg_busy, div_restart, div_val}, {3'b000, 4'd4});

        // Equal write in RUN is a no-op
        drive_wr(1'b1, 1'b1, 4'd4);
        cnt_en = 1'b0;
        step("en2_model");
        step("eq_wr_model");
        chk("eq_wr_nobusy", {cfg_busy, div_val}, {1'b0, 4'd4});

        // Write and halt together enter HALT with shadow; disable written in HALT
        drive_wr(1'b1, 1'b0, 4'd11);
        dbg_halt_req = 1'b1;
        step("wr_halt_model");
        chk("wr_halt", {halt_req, cfg_busy, div_val}, {2'b11, 4'd4});
        drive_wr(1'b0, 1'b0, 4'd12);
        step("halt_dis_wr_model");
        idle();
        dbg_halt_req = 1'b0;
        step("halt_dis_rel_model");
        chk("halt_dis_rel", {timer_en, div_restart, div_val}, {2'b00, 4'd12});

        // Pending without cnt_en
        drive_wr(1'b1, 1'b1, 4'd1);
        step("en3_model");
        drive_wr(1'b1, 1'b1, 4'd6);
        step("pend4_model");
        idle();
`ifdef TIMER_CFG_TIMEOUT_EN
        repeat (255) step("tmo_wait_model");
        chk("tmo_still_busy", {cfg_busy, div_val}, {1'b1, 4'd1});
        step("tmo_fire_model");
        chk("tmo_fire", {cfg_busy, div_restart, div_val}, {2'b01, 4'd6});
`else
        repeat (1000) step("no_tmo_model");
        chk("no_tmo_busy", {cfg_busy, div_val}, {1'b1, 4'd1});
        cnt_en = 1'b1;
        step("no_tmo_apply_model");
        cnt_en = 1'b0;
`endif

        // Reset mid-HALT with pending update
        drive_wr(1'b1, 1'b1, 4'd8);
        step("pend5_model");
        idle();
        dbg_halt_req = 1'b1;
        step("halt2_model");
        step("halt2b_model");
        pulse_reset("rst_mid_halt");
        for (int i = 0; i < 3; i++) begin
            step("post_rst_model");
            chk("post_rst_quiet", {timer_en, div_restart, halt_req}, 10'd0);
        end
        dbg_halt_req = 1'b0;

        // Random traffic
        hold_halt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cfg_wr       = ($urandom_range(0, 4) == 0);
            cfg_timer_en = ($urandom_range(0, 9) != 0);
            cfg_div_en   = 1'($urandom_range(0, 1));
            cfg_div_val  = ($urandom_range(0, 1) == 1) ? 4'd3 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) hold_halt = ~hold_halt;
            dbg_mode     = ($urandom_range(0, 7) != 0);
            dbg_halt_req = hold_halt;
            cnt_en       = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset("rand_rst");
            else step("rand_model");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_cfg_sequencer.md
TIMER_CFG_SEQUENCER -- requirements
Module: timer_cfg_sequencer

Interface
REQ-001 SHALL have: sys_clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: cfg_wr  in  1  one-cycle software config write strobe.
REQ-004 SHALL have: cfg_timer_en / cfg_div_en  in  1 each  written enable values.
REQ-005 SHALL have: cfg_div_val  in  4  written prescaler select.
REQ-006 SHALL have: dbg_mode, dbg_halt_req  in  1 each  debug halt request; halt_in = dbg_mode & dbg_halt_req.
REQ-007 SHALL have: cnt_en  in  1  prescaler tick from counter control (boundary marker).
REQ-008 SHALL have: timer_en, div_en  out  1 each  applied enables to counter control.
REQ-009 SHALL have: div_val  out  4  applied prescaler select.
REQ-010 SHALL have: halt_req  out  1; halt_ack  out  1  debug handshake.
REQ-011 SHALL have: cfg_busy  out  1  update pending; div_restart  out  1  one-cycle pulse on applied running update.

Function
REQ-012 SHALL implement states DIS, RUN, PEND, HALT; all outputs registered.
REQ-013 DIS: cfg_wr loads div_en/div_val next cycle; cfg_timer_en=1 also sets timer_en and goes to RUN; halt_in ignored.
REQ-014 RUN: cfg_wr with cfg_timer_en=0 -> clear timer_en, load div fields, go DIS next cycle.
REQ-015 RUN: cfg_wr with cfg_timer_en=1 and div fields equal to applied -> no change; different -> capture shadow, cfg_busy=1, go PEND.
REQ-016 PEND: first cycle with cnt_en=1 -> apply shadow to div_en/div_val, pulse div_restart, clear cfg_busy, go RUN; outputs change on the following edge.
REQ-017 PEND: cfg_wr with cfg_timer_en=1 overwrites shadow; if same cycle has cnt_en=1, newly written values are applied.
REQ-018 PEND: cfg_wr with cfg_timer_en=0 -> drop pending, apply written fields, clear timer_en, go DIS.
REQ-019 RUN/PEND: halt_in=1 -> go HALT; pending shadow and cfg_busy retained.
REQ-020 Simultaneous halt_in and cfg_wr in RUN/PEND: write with cfg_timer_en=0 wins (DIS); otherwise write enters shadow (cfg_busy=1) and state goes HALT.
REQ-021 HALT: halt_req=1; halt_ack=1 from second cycle in HALT; all writes go to shadow (incl. timer_en), cfg_busy=1; no outputs to counter change.
REQ-022 HALT with halt_in=0: halt_req, halt_ack clear next cycle; if pending, apply shadow in the same update (timer_en=0 -> DIS, else RUN with div_restart pulse); if not pending, go RUN.
REQ-023 div_restart SHALL pulse only on applied updates while timer_en stays 1; never in DIS.

Reset
REQ-024 On sys_rst_n=0: state DIS; timer_en, div_en, halt_req, halt_ack, cfg_busy, div_restart = 0; div_val = 4'h0; shadow and timeout counter cleared.
REQ-025 Reset mid-PEND or mid-HALT SHALL discard pending update with no div_restart pulse.

Configuration
REQ-026 Macro TIMER_CFG_TIMEOUT_EN defined: 8-bit counter clears on PEND entry and on each cfg_wr in PEND, increments each PEND cycle; on reaching 255 with no cnt_en, apply shadow as REQ-016; counter frozen in HALT.
REQ-027 TIMER_CFG_TIMEOUT_EN undefined: no timeout counter; PEND exits only via cnt_en, cfg_wr (timer_en=0), halt, or reset.

Verification
REQ-028 Reset, cfg_wr{timer_en=1,div_en=1,div_val=3} in DIS -> next cycle timer_en=1, div_val=3, state RUN, div_restart=0.
REQ-029 RUN div_val=3, cfg_wr div_val=5, cnt_en pulses 4 cycles later -> cfg_busy=1 for those cycles; div_val=5 and div_restart=1 one cycle after cnt_en.
REQ-030 PEND, then halt_in=1 -> halt_req next cycle, halt_ack one cycle later; write div_val=2 during HALT; release -> halt_req=0, div_val=2, div_restart=1 on same edge.
REQ-031 PEND, cfg_wr{timer_en=0} same cycle as cnt_en -> timer_en=0, cfg_busy=0, DIS, no div_restart.
REQ-032 TIMER_CFG_TIMEOUT_EN defined, PEND with cnt_en held 0 -> apply after 256 PEND cycles; undefined -> still pending after 1000 cycles.
REQ-033 Assert sys_rst_n=0 mid-HALT with pending update -> all outputs 0 immediately, no div_restart after release.
